glip_ingress_upsizer: RTL and testbench
=======================================

// Module: glip_ingress_upsizer
//
// PURPOSE
//  Width upsizer on the host->FPGA path, directly downstream of the Cypress FX3
//  toplevel's fifo_in_* interface, in the logic clock domain. Packs RATIO
//  consecutive IN_WIDTH words into one IN_WIDTH*RATIO word for attached logic.
//  Sustains one input word per cycle, with ready/valid on both sides.
//
// PARAMETERS
//  IN_WIDTH   16  width of incoming words (matches the toplevel's WIDTH)
//  RATIO      2   input words per output word; legal range 2..8
//  OUT_WIDTH  IN_WIDTH*RATIO  derived (localparam), not overridable
//
// PORTS
//  clk        in   1          logic clock (same clk as the toplevel's fifo_* signals)
//  rst        in   1          asynchronous, active-high reset
//  clear      in   1          sync clear: discard partial word and output register (drive from com_rst)
//  in_valid   in   1          input word valid (from fifo_in_valid)
//  in_ready   out  1          input word accepted when in_valid & in_ready
//  in_data    in   IN_WIDTH   input word (from fifo_in_data)
//  out_valid  out  1          assembled word valid
//  out_ready  in   1          consumer accepts when out_valid & out_ready
//  out_data   out  OUT_WIDTH  assembled word
//  partial    out  1          1 while 1..RATIO-1 slices are held in the assembly buffer
//
// BEHAVIOUR
//  Reset (rst=1, async): cnt=0, out_valid=0, out_data=0, partial=0; buffer zeroed.
//  in_ready is 1 immediately after reset deassertion.
//  State: slice counter cnt in 0..RATIO-1 ($clog2(RATIO) bits); assembly buffer of
//  (RATIO-1) slices; output register out_data/out_valid.
//  Ordering: first accepted slice -> out_data[OUT_WIDTH-1 -: IN_WIDTH] (MSB);
//  last slice -> out_data[IN_WIDTH-1:0].
//  in_ready = (cnt != RATIO-1) | ~out_valid | out_ready (combinational; no in_valid dependence).
//  Accept with cnt<RATIO-1: store in_data as slice cnt; cnt <= cnt+1.
//  Accept with cnt==RATIO-1: out_data <= {buffer, in_data}; out_valid <= 1; cnt <= 0.
//  Output handshake: out_valid & out_ready with no concurrent completion -> out_valid <= 0.
//  Simultaneous output pop and completion -> out_valid stays 1 and out_data is replaced
//  (no bubble). Latency: out_valid rises the cycle after the last slice is accepted.
//  Full throughput: one word per cycle continuously when out_ready=1; RATIO in-words
//  per out-word.
//  Backpressure: out_valid=1, out_ready=0, cnt==RATIO-1 -> in_ready=0; earlier slices
//  are still accepted. out_data/out_valid stay stable while out_valid & ~out_ready.
//  partial = (cnt != 0), registered-equivalent (derived from cnt only).
//  clear=1 (sync, priority over all handshakes that cycle): cnt <= 0, out_valid <= 0;
//  any input accepted that cycle is dropped. in_ready remains as per the formula.
//  rst asserted mid-word: partial slices and pending output are lost; no output
//  glitch beyond the async reset values.
//  No wrap hazard: cnt only counts to RATIO-1, then returns to 0.
//
// TESTING
//  1. RATIO=2, out_ready=1, stream 0x1111,0x2222,0x3333,0x4444 back-to-back ->
//     0x11112222 then 0x33334444 on consecutive-pair cycles; in_ready stays 1 throughout.
//  2. out_ready=0 and feed 3 words -> out_valid=1 (0x11112222), 3rd word accepted
//     (partial=1), in_ready=0 on the 4th; raise out_ready -> 4th accepted same cycle,
//     out_data becomes 0x33334444 next cycle.
//  3. RATIO=4: feed 0xA,0xB,0xC,0xD (16-bit) -> out_data=0x000A000B000C000D;
//     partial goes 1,1,1,0.
//  4. Feed one word, pulse clear, feed 0x5555,0x6666 -> only 0x55556666 is emitted;
//     the cleared word never appears.
//  5. Assert rst asynchronously (mid-cycle) with out_valid=1 and partial=1 ->
//     out_valid=0, partial=0 immediately; the next two words form a clean output.
//  6. Random in_valid/out_ready (10k words, both 50%) -> scoreboard matches packed
//     order; no loss or duplication.

Source files
------------

// File: rtl/glip_ingress_upsizer.sv
// Ingress width upsizer: packs RATIO consecutive IN_WIDTH words from the FX3 fifo_in
// interface into one OUT_WIDTH word. The first accepted slice lands in the MSBs.
module glip_ingress_upsizer #(
  parameter int IN_WIDTH = 16,
  parameter int RATIO = 2,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 partial
);

  localparam int CNT_W = $clog2(RATIO);
  localparam int BUF_W = (RATIO - 1) * IN_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [BUF_W-1:0] asm_buf;
  logic             last_slice;
  logic             accept;

  assign last_slice = (cnt == LAST);
  // Only the completing slice needs a free output register; earlier slices always fit.
  assign in_ready   = ~last_slice | ~out_valid | out_ready;
  assign accept     = in_valid & in_ready;
  assign partial    = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      asm_buf   <= '0;
    end else if (clear) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (accept && last_slice) begin
      // Completion overrides any concurrent pop, so the output never bubbles.
      out_data  <= {asm_buf, in_data};
      out_valid <= 1'b1;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < RATIO - 1; i++)
          if (cnt == CNT_W'(i))
            asm_buf[(RATIO-2-i)*IN_WIDTH +: IN_WIDTH] <= in_data;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_glip_ingress_upsizer.sv
// Bench for glip_ingress_upsizer: RATIO=2 instance with a cycle-accurate scoreboard,
// RATIO=4 instance for directed packing checks.
module tb_glip_ingress_upsizer;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        in_valid, in_ready, out_valid, out_ready, partial;
  logic [15:0] in_data;
  logic [31:0] out_data;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, partial4;
  logic [15:0] in_data4;
  logic [63:0] out_data4;

  always #5 clk = ~clk;

  glip_ingress_upsizer #(.IN_WIDTH(16), .RATIO(2)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .partial(partial));

  glip_ingress_upsizer #(.IN_WIDTH(16), .RATIO(4)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .partial(partial4));

  int errors = 0;
  int checks = 0;
  int stall  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the RATIO=2 instance, evaluated on the falling edge.
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] sent_q[$];
  logic [15:0] m_hi;
  int          m_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_partial", 64'(partial), 64'(0));
    end else begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
      chk("partial", 64'(partial), 64'(m_cnt != 0));
      chk("in_ready", 64'(in_ready), 64'((m_cnt != 1) || (exp_q.size() == 0) || out_ready));
      if (clear) begin
        exp_q.delete();
        m_cnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          sent_q.push_back(in_data);
          if (m_cnt == 0) begin
            m_hi  = in_data;
            m_cnt = 1;
          end else begin
            exp_q.push_back({m_hi, in_data});
            m_cnt = 0;
          end
        end
      end
    end
  end

  // Presents one word and holds it until accepted; leaves in_valid high.
  task automatic send(input logic [15:0] d);
    logic ok;
    int   t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      stall++;
      t++;
      if (t > 200) begin
        chk("send_timeout", 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] w4[4];
  logic        p4[4];
  bit          rnd_done;

  initial begin
    rst = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_out_data4", out_data4, 64'(0));
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_partial4", 64'(partial4), 64'(0));
    @(posedge clk);
    #1;

    // Back-to-back stream, consumer always ready.
    got_q.delete();
    out_ready = 1'b1;
    stall = 0;
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    idle(3);
    chk("t1_stall", 64'(stall), 64'(0));
    chk("t1_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      chk("t1_word0", 64'(got_q[0]), 64'h11112222);
      chk("t1_word1", 64'(got_q[1]), 64'h33334444);
    end

    // Output backpressure blocks only the completing slice.
    got_q.delete();
    out_ready = 1'b0;
    send(16'h1111); send(16'h2222); send(16'h3333);
    in_data = 16'h4444;
    chk("t2_out_valid", 64'(out_valid), 64'(1));
    chk("t2_out_data", 64'(out_data), 64'h11112222);
    chk("t2_partial", 64'(partial), 64'(1));
    chk("t2_in_ready_blocked", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("t2_held_data", 64'(out_data), 64'h11112222);
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready_released", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t2_replaced_valid", 64'(out_valid), 64'(1));
    chk("t2_replaced_data", 64'(out_data), 64'h33334444);
    chk("t2_partial_after", 64'(partial), 64'(0));
    idle(2);
    chk("t2_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      chk("t2_word0", 64'(got_q[0]), 64'h11112222);
      chk("t2_word1", 64'(got_q[1]), 64'h33334444);
    end

    // RATIO=4 packing and partial sequence.
    w4 = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    p4 = '{1'b1, 1'b1, 1'b1, 1'b0};
    out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_data4  = w4[i];
      #1;
      chk($sformatf("t3_in_ready_%0d", i), 64'(in_ready4), 64'(1));
      @(posedge clk);
      #1;
      chk($sformatf("t3_partial_%0d", i), 64'(partial4), 64'(p4[i]));
    end
    in_valid4 = 1'b0;
    chk("t3_out_valid", 64'(out_valid4), 64'(1));
    chk("t3_out_data", out_data4, 64'h000A000B000C000D);
    @(posedge clk);
    #1;
    chk("t3_popped", 64'(out_valid4), 64'(0));

    // Clear discards a partial word.
    got_q.delete();
    send(16'h7777);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("t4_partial_cleared", 64'(partial), 64'(0));
    send(16'h5555); send(16'h6666);
    idle(3);
    chk("t4_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) chk("t4_word", 64'(got_q[0]), 64'h55556666);

    // Asynchronous reset mid-cycle with pending output and partial slice.
    got_q.delete();
    out_ready = 1'b0;
    send(16'h0001); send(16'h0002); send(16'h0003);
    in_valid = 1'b0;
    chk("t5_pre_valid", 64'(out_valid), 64'(1));
    chk("t5_pre_partial", 64'(partial), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'(0));
    chk("t5_async_partial", 64'(partial), 64'(0));
    chk("t5_async_data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(16'h8888); send(16'h9999);
    idle(3);
    chk("t5_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) chk("t5_word", 64'(got_q[0]), 64'h88889999);

    // Random valid/ready traffic, 10k words.
    got_q.delete();
    sent_q.delete();
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          while ($urandom_range(1, 0) == 1) idle(1);
          send(16'($urandom));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    out_ready = 1'b1;
    idle(5);
    chk("t6_sent", 64'(sent_q.size()), 64'(10000));
    chk("t6_count", 64'(got_q.size()), 64'(5000));
    if (got_q.size() == 5000 && sent_q.size() == 10000) begin
      for (int i = 0; i < 5000; i++)
        chk($sformatf("t6_word_%0d", i), 64'(got_q[i]), 64'({sent_q[2*i], sent_q[2*i+1]}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
